// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - single-outstanding read/write cache controller, write-through with allocate
//
// Purpose:
//   Accepts one CPU request at a time. Reads look up the external cache and
//   complete in one cycle on a hit. Misses fetch from memory and refill the
//   cache. Writes go straight to memory and update the cache in the handshake
//   cycle.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/ready/we/addr/wdata CPU request channel
//   resp_valid, resp_rdata       one-cycle completion pulse and read data
//   c_addr, c_hit, c_data        cache lookup (c_hit/c_data combinational from c_addr)
//   c_update, c_update_addr/data cache update strobe and payload
//   mem_valid/ready/we/addr/wdata memory request channel
//   mem_rvalid, mem_rdata        memory read return
//   hit_count, miss_count        lookup statistics (only with CACHE_CTRL_STATS_EN)
//
// Configuration:
//   CACHE_CTRL_STATS_EN  define to add saturating hit/miss counters.

module cache_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic [XLEN-1:0] c_addr,
  input  logic            c_hit,
  input  logic [XLEN-1:0] c_data,
  output logic            c_update,
  output logic [XLEN-1:0] c_update_addr,
  output logic [XLEN-1:0] c_update_data,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_valid) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == S_MEM_WAIT && mem_rvalid) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  // Request fields are driven from the latched copy so they stay stable
  // while memory back-pressures.
  assign c_addr        = r_addr;
  assign c_update_addr = r_addr;
  assign mem_addr      = r_addr;
  assign mem_we        = r_we;
  assign mem_wdata     = r_wdata;

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = r_rdata;
    mem_valid     = 1'b0;
    c_update      = 1'b0;
    c_update_data = r_wdata;
    if (rst) begin
      // Strobes held low while in reset so an abandoned transfer leaves no trace.
      resp_rdata = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            w_next = req_we ? S_MEM_REQ : S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (c_hit) begin
            resp_valid = 1'b1;
            resp_rdata = c_data;
            w_next     = S_IDLE;
          end else begin
            w_next = S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          mem_valid = 1'b1;
          if (mem_ready) begin
            if (r_we) begin
              // Write-allocate: refresh the cache in the handshake cycle.
              c_update = 1'b1;
              w_next   = S_RESP;
            end else begin
              w_next = S_MEM_WAIT;
            end
          end
        end
        S_MEM_WAIT: begin
          if (mem_rvalid) begin
            c_update      = 1'b1;
            c_update_data = mem_rdata;
            w_next        = S_RESP;
          end
        end
        S_RESP: begin
          resp_valid = 1'b1;
          w_next     = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (c_hit) begin
        if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
      end else begin
        if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard testbench for cache_ctrl

module tb_cache_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] c_addr;
  logic        c_hit;
  logic [31:0] c_data;
  logic        c_update;
  logic [31:0] c_update_addr;
  logic [31:0] c_update_data;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_ctrl #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .c_addr        (c_addr),
    .c_hit         (c_hit),
    .c_data        (c_data),
    .c_update      (c_update),
    .c_update_addr (c_update_addr),
    .c_update_data (c_update_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Cache model: small fully associative store answering lookups combinationally.
  logic [31:0] ctag [8];
  logic [31:0] cdat [8];
  logic        cval [8];
  int          cnext;

  always_comb begin
    c_hit  = 1'b0;
    c_data = '0;
    for (int i = 0; i < 8; i++) begin
      if (cval[i] && ctag[i] == c_addr) begin
        c_hit  = 1'b1;
        c_data = cdat[i];
      end
    end
  end

  function automatic bit cache_has(input logic [31:0] a);
    for (int i = 0; i < 8; i++) if (cval[i] && ctag[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cache_put(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 8; i++) begin
      if (cval[i] && ctag[i] == a) begin
        cdat[i] = d;
        return;
      end
    end
    ctag[cnext] = a;
    cdat[cnext] = d;
    cval[cnext] = 1'b1;
    cnext = (cnext + 1) % 8;
  endtask

  // Memory responder: programmable ready and read-return delays, driven on negedge.
  logic [31:0] mem_model [logic [31:0]];
  int ready_dly  = 0;
  int rvalid_dly = 0;
  int inject_cnt = 0;

  initial begin
    int          ready_cnt;
    int          rv_cnt;
    int          inject_seen;
    bit          rd_pend;
    logic [31:0] rd_addr;
    ready_cnt   = 0;
    rv_cnt      = 0;
    inject_seen = 0;
    rd_pend     = 1'b0;
    rd_addr     = '0;
    mem_ready   = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    mem_model[32'h100] = 32'hDEAD_BEEF;
    mem_model[32'h200] = 32'h1234_5678;
    mem_model[32'h400] = 32'h0F0F_0F0F;
    mem_model[32'h503] = 32'h0BAD_F00D;
    forever begin
      @(negedge clk);
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (rst) begin
        ready_cnt = 0;
        rd_pend   = 1'b0;
      end else if (inject_cnt != inject_seen) begin
        inject_seen = inject_cnt;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'h5A5A_5A5A;
      end else begin
        if (rd_pend) begin
          if (rv_cnt >= rvalid_dly) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_model[rd_addr];
            rd_pend    = 1'b0;
          end else rv_cnt++;
        end
        if (mem_valid) begin
          if (ready_cnt >= ready_dly) begin
            mem_ready = 1'b1;
            ready_cnt = 0;
            if (mem_we) mem_model[mem_addr] = mem_wdata;
            else begin
              rd_pend = 1'b1;
              rv_cnt  = 0;
              rd_addr = mem_addr;
            end
          end else ready_cnt++;
        end
      end
    end
  end

  // Scoreboard: expectation pushed on acceptance, popped on resp_valid.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        hit;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_mem [logic [31:0]];
  int          n_upd   = 0;
  int          n_resp  = 0;
  int          mv_seen = 0;

  initial begin
    exp_t        e;
    int          upd_cyc;
    int          upd_this;
    logic        prev_mv;
    logic        prev_mr;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_we;
    upd_cyc  = 0;
    upd_this = 0;
    prev_mv  = 1'b0;
    prev_mr  = 1'b0;
    p_addr   = '0;
    p_wdata  = '0;
    p_we     = 1'b0;
    cnext    = 0;
    for (int i = 0; i < 8; i++) begin
      cval[i] = 1'b0;
      ctag[i] = '0;
      cdat[i] = '0;
    end
    cache_put(32'h100, 32'hDEAD_BEEF);
    exp_mem[32'h100] = 32'hDEAD_BEEF;
    exp_mem[32'h200] = 32'h1234_5678;
    exp_mem[32'h400] = 32'h0F0F_0F0F;
    exp_mem[32'h503] = 32'h0BAD_F00D;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        q.delete();
        upd_this = 0;
        prev_mv  = 1'b0;
        continue;
      end
      if (mem_valid) mv_seen++;
      if (mem_valid && prev_mv && !prev_mr) begin
        chk("mem_addr_stable", mem_addr, p_addr);
        chk("mem_wdata_stable", mem_wdata, p_wdata);
        chk("mem_we_stable", 32'(mem_we), 32'(p_we));
      end
      prev_mv = mem_valid;
      prev_mr = mem_ready;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
      p_we    = mem_we;
      if (req_valid && req_ready) begin
        e.we   = req_we;
        e.addr = req_addr;
        e.data = req_we ? req_wdata : exp_mem[req_addr];
        e.hit  = !req_we && cache_has(req_addr);
        e.acc  = cyc;
        q.push_back(e);
        if (req_we) exp_mem[req_addr] = req_wdata;
      end
      if (c_update) begin
        n_upd++;
        upd_this++;
        upd_cyc = cyc;
        if (q.size() == 0) chk("upd_unexpected", 32'd1, 32'd0);
        else begin
          chk("upd_addr", c_update_addr, q[0].addr);
          chk("upd_data", c_update_data, q[0].data);
          if (q[0].we) chk("upd_in_handshake", 32'(mem_valid && mem_ready), 32'd1);
        end
        cache_put(c_update_addr, c_update_data);
      end
      if (resp_valid) begin
        n_resp++;
        if (q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          if (!e.we) chk("rdata", resp_rdata, e.data);
          if (e.hit) begin
            chk("hit_latency", 32'(cyc - e.acc), 32'd1);
            chk("hit_no_update", 32'(upd_this), 32'd0);
          end else begin
            chk("resp_after_update", 32'(cyc - upd_cyc), 32'd1);
            chk("update_once", 32'(upd_this), 32'd1);
          end
        end
        upd_this = 0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("req_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_c_update", 32'(c_update), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
  endtask

  logic [31:0] b2b_addr [3];

  initial begin
    int m0;
    int u0;
    int r0;
    int i;
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    b2b_addr[0] = 32'h100;
    b2b_addr[1] = 32'h200;
    b2b_addr[2] = 32'h503;

    repeat (3) @(negedge clk);
    #2;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Read hit on preloaded line.
    m0 = mv_seen;
    do_req(1'b0, 32'h100, 32'h0);
    wait_done();
    chk("hit_mem_idle", 32'(mv_seen - m0), 32'd0);

    // Read miss with delayed handshake and return, then a repeat hit.
    ready_dly  = 2;
    rvalid_dly = 3;
    u0 = n_upd;
    do_req(1'b0, 32'h200, 32'h0);
    wait_done();
    chk("miss_update_count", 32'(n_upd - u0), 32'd1);
    m0 = mv_seen;
    do_req(1'b0, 32'h200, 32'h0);
    wait_done();
    chk("repeat_hit_mem_idle", 32'(mv_seen - m0), 32'd0);
`ifdef CACHE_CTRL_STATS_EN
    chk("hit_count", hit_count, 32'd2);
    chk("miss_count", miss_count, 32'd1);
`endif

    // Write under back-pressure, then read it back from the cache.
    ready_dly = 4;
    do_req(1'b1, 32'h300, 32'hCAFE_F00D);
    wait_done();
    chk("mem_written", mem_model[32'h300], 32'hCAFE_F00D);
    do_req(1'b0, 32'h300, 32'h0);
    wait_done();

    // Back-to-back reads with req_valid held high; unaligned address passes through.
    ready_dly  = 1;
    rvalid_dly = 1;
    r0 = n_resp;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = b2b_addr[0];
    i = 0;
    n = 0;
    while (i < 3 && n < 200) begin
      if (req_ready) begin
        @(negedge clk);
        i++;
        if (i < 3) req_addr = b2b_addr[i];
      end else @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    if (n >= 200) chk("b2b_timeout", 32'd0, 32'd1);
    wait_done();
    chk("b2b_resp_count", 32'(n_resp - r0), 32'd3);

    // Reset while waiting for read data, followed by a stray late return.
    ready_dly  = 0;
    rvalid_dly = 20;
    do_req(1'b0, 32'h400, 32'h0);
    n = 0;
    while (!(mem_valid && mem_ready) && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 20) chk("handshake_timeout", 32'd0, 32'd1);
    @(negedge clk);
    u0 = n_upd;
    r0 = n_resp;
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("ready_after_mid_reset", 32'(req_ready), 32'd1);
    inject_cnt++;
    repeat (5) @(negedge clk);
    chk("abandon_no_update", 32'(n_upd - u0), 32'd0);
    chk("abandon_no_resp", 32'(n_resp - r0), 32'd0);

    // Recovery: the abandoned line was never allocated, so this misses cleanly.
    rvalid_dly = 1;
    u0 = n_upd;
    do_req(1'b0, 32'h400, 32'h0);
    wait_done();
    chk("recover_update_count", 32'(n_upd - u0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter XLEN, default 32, data and address width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  XLEN  request byte address.
REQ-008 req_wdata  input  XLEN  write data.
REQ-009 resp_valid  output  1  one-cycle completion pulse.
REQ-010 resp_rdata  output  XLEN  read data; don't-care for writes.
REQ-011 c_addr  output  XLEN  cache lookup address.
REQ-012 c_hit  input  1  cache lookup hit (combinational from c_addr).
REQ-013 c_data  input  XLEN  cache lookup data.
REQ-014 c_update  output  1  cache update strobe.
REQ-015 c_update_addr  output  XLEN  cache update address.
REQ-016 c_update_data  output  XLEN  cache update data.
REQ-017 mem_valid  output  1  memory request valid.
REQ-018 mem_ready  input  1  memory accepts the request.
REQ-019 mem_we  output  1  memory write.
REQ-020 mem_addr  output  XLEN  memory address.
REQ-021 mem_wdata  output  XLEN  memory write data.
REQ-022 mem_rvalid  input  1  memory read data valid.
REQ-023 mem_rdata  input  XLEN  memory read data.

Function
REQ-024 States SHALL be: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP; at most one request is outstanding.
REQ-025 IDLE: req_ready=1; on req_valid, latch we/addr/wdata; a read goes to LOOKUP, a write goes to MEM_REQ.
REQ-026 req_ready SHALL be 0 in every state except IDLE; req_valid is ignored when req_ready=0.
REQ-027 c_addr SHALL equal the latched address in all states.
REQ-028 LOOKUP, c_hit=1: resp_valid=1, resp_rdata=c_data, then IDLE; read-hit latency is exactly 1 cycle after acceptance.
REQ-029 LOOKUP, c_hit=0: go to MEM_REQ.
REQ-030 MEM_REQ: mem_valid=1 and mem_addr/mem_we/mem_wdata come from the latched request; they are held stable until mem_ready=1.
REQ-031 MEM_REQ handshake, read: go to MEM_WAIT.
REQ-032 MEM_REQ handshake, write (write-through, write-allocate): c_update=1 with the latched addr/wdata in that same cycle, then go to RESP.
REQ-033 MEM_WAIT: on mem_rvalid, c_update=1 with c_update_addr=latched addr and c_update_data=mem_rdata; capture mem_rdata; go to RESP.
REQ-034 RESP: resp_valid=1 for one cycle; resp_rdata=captured data; go to IDLE.
REQ-035 mem_rvalid outside MEM_WAIT SHALL be ignored.
REQ-036 mem_ready outside MEM_REQ SHALL be ignored.
REQ-037 c_update SHALL be asserted for at most one cycle per request, and never in IDLE or LOOKUP.
REQ-038 Address low bits SHALL pass through unmodified; the controller does no alignment checks.

Reset
REQ-039 While rst=1: state=IDLE; req_ready, resp_valid, mem_valid and c_update are 0; latched registers and resp_rdata are 0.
REQ-040 rst asserted mid-operation SHALL abandon the transaction with no resp_valid and no c_update; the memory side must be reset concurrently.
REQ-041 req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-042 Macro CACHE_CTRL_STATS_EN defined: add outputs hit_count[31:0] and miss_count[31:0], both reset to 0, each saturating at 32'hFFFFFFFF.
REQ-043 hit_count increments on each LOOKUP with c_hit=1; miss_count increments on each LOOKUP with c_hit=0; writes count in neither.
REQ-044 Macro CACHE_CTRL_STATS_EN undefined: the ports and counters SHALL be absent, and all other behaviour is identical.

Verification
REQ-045 Read hit: cache preloaded with 0x100 -> 0xDEADBEEF; read 0x100 accepted cycle N -> resp_valid=1 and resp_rdata=0xDEADBEEF in cycle N+1; mem_valid stays 0.
REQ-046 Read miss: read 0x200, mem_ready after 2 cycles, mem_rvalid with 0x12345678 after 3 more -> c_update(0x200, 0x12345678) once; resp_rdata=0x12345678; a repeat read of 0x200 hits in 1 cycle.
REQ-047 Write: write 0x300 = 0xCAFEF00D, mem_ready held 0 for 4 cycles -> mem_valid, mem_addr and mem_wdata stable throughout; c_update in the handshake cycle; resp_valid the next cycle.
REQ-048 Back-to-back: req_valid held high across 3 reads -> each accepted only when req_ready=1; exactly 3 resp_valid pulses, in order.
REQ-049 Reset in MEM_WAIT: rst pulsed, then a late mem_rvalid arrives -> no c_update, no resp_valid; req_ready=1 after reset.
REQ-050 With CACHE_CTRL_STATS_EN: after scenarios REQ-045 and REQ-046 -> hit_count=2, miss_count=1.
